hpdl1414_scanner: RTL

Display-side reader of the 16-entry display buffer. On every refresh tick it walks all 16 buffer addresses through the buffer's registered read port and rewrites each character into a bank of four HPDL-1414 4-digit displays over their shared parallel write bus, with programmable setup, strobe and hold timing. It also generates the caret-blink strobe that the buffer uses to swap the most recently written position with the caret character.

---
 rtl/hpdl1414_scanner_if.sv | 26 ++
 rtl/hpdl1414_scanner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hpdl1414_scanner_if.sv
// rtl/hpdl1414_scanner_if.sv - buffer read port and HPDL-1414 write bus bundle
interface hpdl1414_scanner_if;
  logic       o_read_enable;
  logic [3:0] o_read_address;
  logic [7:0] i_read_data;
  logic       o_caret_strobe;
  logic [6:0] o_hpdl_data;
  logic [1:0] o_hpdl_addr;
  logic [3:0] o_hpdl_wr_n;
  logic       o_busy;
  logic       o_frame_done;

  // Scanner side: drives the buffer read port and the display bus
  modport master (
    output o_read_enable, o_read_address, o_caret_strobe,
    output o_hpdl_data, o_hpdl_addr, o_hpdl_wr_n, o_busy, o_frame_done,
    input  i_read_data
  );

  // Buffer/display side
  modport slave (
    input  o_read_enable, o_read_address, o_caret_strobe,
    input  o_hpdl_data, o_hpdl_addr, o_hpdl_wr_n, o_busy, o_frame_done,
    output i_read_data
  );
endinterface

// File: rtl/hpdl1414_scanner.sv
// rtl/hpdl1414_scanner.sv - refreshes four HPDL-1414 displays from the 16-entry buffer
module hpdl1414_scanner #(
  parameter int SETUP_CYCLES = 2,
  parameter int WR_CYCLES    = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int REFRESH_DIV  = 4096,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  hpdl1414_scanner_if.master  bus
);

  localparam int MAX_PHASE = (SETUP_CYCLES > WR_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((WR_CYCLES > HOLD_CYCLES) ? WR_CYCLES : HOLD_CYCLES);
  localparam int PW = $clog2(MAX_PHASE + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t        state;
  logic [3:0]    digit;
  logic [PW-1:0] phase_cnt;
  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  logic          tick;
  logic          unused_read_msb;

  // Bit 7 of the buffer byte carries no character information
  assign unused_read_msb = bus.i_read_data[7];

  // Tick is the cycle in which the refresh counter wraps back to zero
  assign tick = (refresh_cnt == RW'(REFRESH_DIV - 1));

  // Map a 7-bit code onto the HPDL-1414 character set (0x20..0x5F, upper case only)
  function automatic logic [6:0] to_hpdl(input logic [6:0] c);
    if (c >= 7'h20 && c <= 7'h5F)
      return c;
    else if (c >= 7'h61 && c <= 7'h7A)
      return c - 7'h20;
    else
      return 7'h20;
  endfunction

  // Free-running refresh divider
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      refresh_cnt <= '0;
    else if (tick)
      refresh_cnt <= '0;
    else
      refresh_cnt <= refresh_cnt + 1'b1;
  end

  // Digit sequencer with registered bus outputs and caret blink
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= ST_IDLE;
      digit              <= '0;
      phase_cnt          <= '0;
      blink_cnt          <= '0;
      bus.o_read_enable  <= 1'b0;
      bus.o_read_address <= '0;
      bus.o_caret_strobe <= 1'b1;
      bus.o_hpdl_data    <= 7'h20;
      bus.o_hpdl_addr    <= '0;
      bus.o_hpdl_wr_n    <= 4'b1111;
      bus.o_busy         <= 1'b0;
      bus.o_frame_done   <= 1'b0;
    end else begin
      bus.o_frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state              <= ST_READ;
            digit              <= '0;
            bus.o_read_enable  <= 1'b1;
            bus.o_read_address <= '0;
            bus.o_busy         <= 1'b1;
          end
        end
        ST_READ: begin
          bus.o_read_enable <= 1'b0;
          state             <= ST_LATCH;
        end
        ST_LATCH: begin
          // Data and address only ever change here, so every chip sees them settled
          bus.o_hpdl_data <= to_hpdl(bus.i_read_data[6:0]);
          bus.o_hpdl_addr <= 2'd3 - digit[1:0];
          phase_cnt       <= '0;
          state           <= ST_SETUP;
        end
        ST_SETUP: begin
          if (phase_cnt == PW'(SETUP_CYCLES - 1)) begin
            phase_cnt       <= '0;
            bus.o_hpdl_wr_n <= ~(4'b0001 << digit[3:2]);
            state           <= ST_STROBE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_STROBE: begin
          if (phase_cnt == PW'(WR_CYCLES - 1)) begin
            phase_cnt       <= '0;
            bus.o_hpdl_wr_n <= 4'b1111;
            state           <= ST_HOLD;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (phase_cnt == PW'(HOLD_CYCLES - 1)) begin
            phase_cnt <= '0;
            if (digit == 4'd15) begin
              state            <= ST_IDLE;
              digit            <= '0;
              bus.o_busy       <= 1'b0;
              bus.o_frame_done <= 1'b1;
              // Caret only flips at frame boundaries, never mid-frame
              if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt          <= '0;
                bus.o_caret_strobe <= ~bus.o_caret_strobe;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end else begin
              digit              <= digit + 1'b1;
              bus.o_read_enable  <= 1'b1;
              bus.o_read_address <= digit + 1'b1;
              state              <= ST_READ;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
